// File: rtl/muldiv_sequencer.sv
// Iterative 32-step multiply/divide sequencer owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide share one accumulator/shift pair.
module muldiv_sequencer #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] ReadData1,
  input  logic [W-1:0] ReadData2,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   acc, lsr, dvs;
  logic [CNT_W-1:0] cnt;
  logic           is_div, sgn_a, sgn_b;

  // op[0]=0 selects the signed flavour of both mult and div.
  logic         a_neg, b_neg;
  logic [W-1:0] mag_a, mag_b;
  assign a_neg = ~op[0] & ReadData1[W-1];
  assign b_neg = ~op[0] & ReadData2[W-1];
  assign mag_a = a_neg ? -ReadData1 : ReadData1;
  assign mag_b = b_neg ? -ReadData2 : ReadData2;

  // Per-step datapath: add for multiply, trial subtract for divide.
  logic [W:0]   add, shl;
  logic [W-1:0] diff;
  logic         no_borrow;
  assign add       = lsr[0] ? ({1'b0, acc} + {1'b0, dvs}) : {1'b0, acc};
  assign shl       = {acc, lsr[W-1]};
  assign no_borrow = shl >= {1'b0, dvs};
  assign diff      = shl[W-1:0] - dvs;

  // Sign fix-up applied once at the end.
  logic           res_neg, div_zero;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;
  assign res_neg  = sgn_a ^ sgn_b;
  assign prod_fix = res_neg ? -{acc, lsr} : {acc, lsr};
  assign quot_fix = res_neg ? -lsr : lsr;
  assign rem_fix  = sgn_a ? -acc : acc;
  assign div_zero = (dvs == '0);

  assign busy = (state != IDLE);

  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(W - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end else if (state == FIX) begin
        if (is_div) begin
          lo <= div_zero ? '1 : quot_fix;
          hi <= rem_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are fully loaded on every accepted start.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        is_div <= op[1];
        sgn_a  <= a_neg;
        sgn_b  <= b_neg;
        acc    <= '0;
        cnt    <= '0;
        if (op[1]) begin
          lsr <= mag_a;
          dvs <= mag_b;
        end else begin
          lsr <= mag_b;
          dvs <= mag_a;
        end
      end
      CALC: begin
        cnt <= cnt + CNT_W'(1);
        if (is_div) begin
          if (no_borrow) begin
            acc <= diff;
            lsr <= {lsr[W-2:0], 1'b1};
          end else begin
            acc <= shl[W-1:0];
            lsr <= {lsr[W-2:0], 1'b0};
          end
        end else begin
          acc <= add[W:1];
          lsr <= {add[0], lsr[W-1:1]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: countdown-based behavioural model compared every cycle,
// plus literal expectations for the directed corner cases.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] ReadData1 = '0, ReadData2 = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_sequencer #(.W(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} from plain arithmetic.
  function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin qv = sa * sb; return qv; end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: an accepted op keeps the unit busy for W+1 cycles, then commits and pulses done.
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start) begin
          m_pend = model_result(op, ReadData1, ReadData2);
          m_rem  = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("done", 64'(done), 64'(m_done));
      check("hi",   64'(hi),   64'(m_hi));
      check("lo",   64'(lo),   64'(m_lo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; ReadData1 = a; ReadData2 = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    bit got = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n = i + 1;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
    int n;
    issue(o, a, b);
    wait_done(n);
    check({name, "_lat"}, 64'(n), 64'(34));
    check({name, "_hi"}, 64'(hi), 64'(e_hi));
    check({name, "_lo"}, 64'(lo), 64'(e_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    rst_n = 1'b1;
    tick();

    run_lit("t1_multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    run_lit("t2_mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    tick();
    run_lit("t2_div", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick();
    run_lit("t3_divu0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    tick();
    run_lit("t3_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    tick();
    run_lit("t3_div0_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    tick();

    // Start and mthi while busy are ignored.
    issue(2'b01, 32'h1234, 32'h10);
    repeat (5) tick();
    start = 1'b1; op = 2'b00; ReadData1 = 32'd99; ReadData2 = 32'd77;
    hi_we = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; hi_we = 1'b0;
    wait_done(n);
    check("t4_lo", 64'(lo), 64'(32'h12340));
    check("t4_hi_not_dead", 64'(hi != 32'hDEAD), 64'(1));
    tick();

    // Mid-operation reset discards the op.
    issue(2'b01, 32'hFFFF, 32'hFFFF);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_hi", 64'(hi), 64'(0));
    check("t5_lo", 64'(lo), 64'(0));
    repeat (40) tick();
    run_lit("t5_fresh", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
    tick();

    // Back-to-back with start held high through the done cycle.
    op = 2'b01; ReadData1 = 32'd3; ReadData2 = 32'd4; start = 1'b1;
    tick();
    wait_done(n);
    check("t6_first_lo", 64'(lo), 64'(12));
    check("t6_gap_busy", 64'(busy), 64'(0));
    op = 2'b11; ReadData1 = 32'd100; ReadData2 = 32'd7;
    tick();
    start = 1'b0;
    wait_done(n);
    check("t6_lat", 64'(n), 64'(34));
    check("t6_hi", 64'(hi), 64'(2));
    check("t6_lo", 64'(lo), 64'(14));
    tick();

    // IDLE mthi/mtlo, including one on the start edge, then randomized ops with noise.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_hi", 64'(hi), 64'(32'hA5A5_0001));
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 3)) begin
        hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
        tick();
      end
      hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
      issue(2'($urandom), pick(), pick());
      hi_we = 1'b0; lo_we = 1'b0;
      repeat ($urandom_range(0, 5)) begin
        start = 1'($urandom); hi_we = 1'($urandom); lo_we = 1'($urandom);
        ReadData1 = $urandom; ReadData2 = $urandom; wdata = $urandom;
        tick();
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      wait_done(n);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
